vga_scan_gen: RTL and testbench

- Raster timing generator that drives the scan position consumed by every render block: 640x480 at 60 Hz, with a 25 MHz pixel cadence derived from the 100 MHz system clock.
- Produces the current pixel counters (h_cnt, v_cnt) and lead counters (ah_cnt, av_cnt). The lead counters run LEAD pixels ahead so that render blocks can issue block-RAM sprite reads early.
- Also produces hsync, vsync, the active-video flag and a per-frame tick for the game logic.

---
 rtl/vga_scan_gen.sv | 107 ++++++++++
 tb/tb_vga_scan_gen.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/vga_scan_gen.sv
// Raster timing generator: pixel-rate divider, current and lead scan counters, sync/valid flags.
// Define VGA_SCAN_FRAME_CNT_EN to build the 8-bit frame counter; otherwise frame_cnt is tied to 0.
module vga_scan_gen #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned LEAD     = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       pix_en,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic [9:0] ah_cnt,
  output logic [9:0] av_cnt,
  output logic       hsync,
  output logic       vsync,
  output logic       valid,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);

  localparam int unsigned H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SYNC_BEG = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_END = H_SYNC_BEG + H_SYNC;
  localparam int unsigned V_SYNC_BEG = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_END = V_SYNC_BEG + V_SYNC;
  localparam int unsigned DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  // Counters are 10 bits wide, so the raster must fit in 1024x1024.
  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 2 || LEAD >= H_TOTAL) begin : g_bad_cfg
      $error("vga_scan_gen: illegal timing parameters");
    end
  endgenerate

  logic [DIV_W-1:0] div_cnt;
  logic [9:0]       h_nxt;
  logic [9:0]       v_nxt;
  logic [9:0]       ah_nxt;
  logic [9:0]       av_nxt;

  assign pix_en      = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign frame_start = pix_en && (h_cnt == 10'd0) && (v_cnt == 10'd0);

  // Next scan position for both the current and the lead counter pair.
  always_comb begin
    h_nxt  = h_cnt + 10'd1;
    v_nxt  = v_cnt;
    ah_nxt = ah_cnt + 10'd1;
    av_nxt = av_cnt;
    if (h_cnt == 10'(H_TOTAL - 1)) begin
      h_nxt = '0;
      v_nxt = (v_cnt == 10'(V_TOTAL - 1)) ? 10'd0 : v_cnt + 10'd1;
    end
    if (ah_cnt == 10'(H_TOTAL - 1)) begin
      ah_nxt = '0;
      av_nxt = (av_cnt == 10'(V_TOTAL - 1)) ? 10'd0 : av_cnt + 10'd1;
    end
  end

  // Flags are decoded from the next position so they line up with h_cnt/v_cnt.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
      ah_cnt  <= 10'(LEAD);
      av_cnt  <= '0;
      hsync   <= 1'b1;
      vsync   <= 1'b1;
      valid   <= 1'b0;
    end else begin
      div_cnt <= pix_en ? '0 : div_cnt + DIV_W'(1);
      if (pix_en) begin
        h_cnt  <= h_nxt;
        v_cnt  <= v_nxt;
        ah_cnt <= ah_nxt;
        av_cnt <= av_nxt;
        hsync  <= !((h_nxt >= 10'(H_SYNC_BEG)) && (h_nxt < 10'(H_SYNC_END)));
        vsync  <= !((v_nxt >= 10'(V_SYNC_BEG)) && (v_nxt < 10'(V_SYNC_END)));
        valid  <= (h_nxt < 10'(H_ACTIVE)) && (v_nxt < 10'(V_ACTIVE));
      end
    end
  end

`ifdef VGA_SCAN_FRAME_CNT_EN
  // Animation phase for render blocks; wraps modulo 256.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (frame_start) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end
`else
  assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_scan_gen.sv
// Directed bench for vga_scan_gen: default 640x480 timing for reset/cadence/line wrap,
// plus a shrunken raster (12x8 pixels, CLK_DIV=2, LEAD=3) for full-frame windows and frame wrap.
module tb_vga_scan_gen;

  logic       clk;
  logic       rst_n;

  logic       d_pix_en, d_hsync, d_vsync, d_valid, d_frame_start;
  logic [9:0] d_h_cnt, d_v_cnt, d_ah_cnt, d_av_cnt;
  logic [7:0] d_frame_cnt;

  logic       s_pix_en, s_hsync, s_vsync, s_valid, s_frame_start;
  logic [9:0] s_h_cnt, s_v_cnt, s_ah_cnt, s_av_cnt;
  logic [7:0] s_frame_cnt;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  vga_scan_gen u_dflt (
    .clk(clk), .rst_n(rst_n), .pix_en(d_pix_en),
    .h_cnt(d_h_cnt), .v_cnt(d_v_cnt), .ah_cnt(d_ah_cnt), .av_cnt(d_av_cnt),
    .hsync(d_hsync), .vsync(d_vsync), .valid(d_valid),
    .frame_start(d_frame_start), .frame_cnt(d_frame_cnt)
  );

  vga_scan_gen #(
    .CLK_DIV(2), .H_ACTIVE(6), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .LEAD(3)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .pix_en(s_pix_en),
    .h_cnt(s_h_cnt), .v_cnt(s_v_cnt), .ah_cnt(s_ah_cnt), .av_cnt(s_av_cnt),
    .hsync(s_hsync), .vsync(s_vsync), .valid(s_valid),
    .frame_start(s_frame_start), .frame_cnt(s_frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  initial begin
    int h, v, p, lp, hs_low, vs_low, val_hi;
    rst_n = 1'b0;
    repeat (10) tick();

    check("rst_h", int'(d_h_cnt), 0);
    check("rst_v", int'(d_v_cnt), 0);
    check("rst_ah", int'(d_ah_cnt), 1);
    check("rst_av", int'(d_av_cnt), 0);
    check("rst_hsync", int'(d_hsync), 1);
    check("rst_vsync", int'(d_vsync), 1);
    check("rst_valid", int'(d_valid), 0);
    check("rst_pix_en", int'(d_pix_en), 0);
    check("rst_frame_cnt", int'(d_frame_cnt), 0);
    check("rst_small_ah", int'(s_ah_cnt), 3);

    // Release: this negedge is cycle 0 after reset.
    rst_n = 1'b1;
    cyc = 0;
    for (int k = 0; k < 12; k++) begin
      check($sformatf("cad_pix_en_%0d", k), int'(d_pix_en), (k % 4 == 3) ? 1 : 0);
      check($sformatf("cad_fstart_%0d", k), int'(d_frame_start), (k == 3) ? 1 : 0);
      check($sformatf("cad_h_%0d", k), int'(d_h_cnt), k / 4);
      tick();
    end

    // Line 0 boundaries on the default raster: pixel h is shown from cycle 4*h.
    run_to(2556); check("valid_h639", int'(d_valid), 1);
    run_to(2560); check("valid_h640", int'(d_valid), 0);
    run_to(2620); check("hsync_h655", int'(d_hsync), 1);
    run_to(2624); check("hsync_h656", int'(d_hsync), 0);
    run_to(3004); check("hsync_h751", int'(d_hsync), 0);
    run_to(3008); check("hsync_h752", int'(d_hsync), 1);
    run_to(3192);
    check("lw798_h", int'(d_h_cnt), 798);
    check("lw798_v", int'(d_v_cnt), 0);
    check("lw798_ah", int'(d_ah_cnt), 799);
    check("lw798_av", int'(d_av_cnt), 0);
    run_to(3193); check("hold_h798", int'(d_h_cnt), 798);
    run_to(3196);
    check("lw799_h", int'(d_h_cnt), 799);
    check("lw799_ah", int'(d_ah_cnt), 0);
    check("lw799_av", int'(d_av_cnt), 1);
    run_to(3200);
    check("lw_next_h", int'(d_h_cnt), 0);
    check("lw_next_v", int'(d_v_cnt), 1);
    check("lw_next_valid", int'(d_valid), 1);

    // Small raster: fresh reset, then sample every pixel of one frame plus the wrap.
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    hs_low = 0; vs_low = 0; val_hi = 0;
    for (int j = 0; j <= 96; j++) begin
      p  = j % 96;
      h  = p % 12;
      v  = p / 12;
      lp = (p + 3) % 96;
      check($sformatf("s_pix_en_%0d", j), int'(s_pix_en), 1);
      check($sformatf("s_h_%0d", j), int'(s_h_cnt), h);
      check($sformatf("s_v_%0d", j), int'(s_v_cnt), v);
      check($sformatf("s_ah_%0d", j), int'(s_ah_cnt), lp % 12);
      check($sformatf("s_av_%0d", j), int'(s_av_cnt), lp / 12);
      check($sformatf("s_hsync_%0d", j), int'(s_hsync), (h >= 8 && h <= 10) ? 0 : 1);
      check($sformatf("s_vsync_%0d", j), int'(s_vsync), (v >= 5 && v <= 6) ? 0 : 1);
      check($sformatf("s_valid_%0d", j), int'(s_valid), (h < 6 && v < 4 && j != 0) ? 1 : 0);
      check($sformatf("s_fstart_%0d", j), int'(s_frame_start), (p == 0) ? 1 : 0);
      if (j < 96) begin
        if (!s_hsync) hs_low++;
        if (!s_vsync) vs_low++;
        if (s_valid) val_hi++;
      end
      if (j == 96) begin
`ifdef VGA_SCAN_FRAME_CNT_EN
        check("s_frame_cnt_wrap", int'(s_frame_cnt), 1);
`else
        check("s_frame_cnt_wrap", int'(s_frame_cnt), 0);
`endif
      end
      tick();
      check($sformatf("s_gap_pix_en_%0d", j), int'(s_pix_en), 0);
      tick();
    end
    check("s_hsync_low_count", hs_low, 24);
    check("s_vsync_low_count", vs_low, 24);
    check("s_valid_high_count", val_hi, 23);

    // Mid-frame reset on a pix_en cycle of the small raster.
    check("mid_pre_pix_en", int'(s_pix_en), 1);
    rst_n = 1'b0;
    tick();
    check("mid_d_h", int'(d_h_cnt), 0);
    check("mid_d_v", int'(d_v_cnt), 0);
    check("mid_d_ah", int'(d_ah_cnt), 1);
    check("mid_d_pix_en", int'(d_pix_en), 0);
    check("mid_s_h", int'(s_h_cnt), 0);
    check("mid_s_v", int'(s_v_cnt), 0);
    check("mid_s_ah", int'(s_ah_cnt), 3);
    check("mid_s_av", int'(s_av_cnt), 0);
    check("mid_s_hsync", int'(s_hsync), 1);
    check("mid_s_vsync", int'(s_vsync), 1);
    check("mid_s_valid", int'(s_valid), 0);
    check("mid_s_pix_en", int'(s_pix_en), 0);
    check("mid_s_frame_cnt", int'(s_frame_cnt), 0);
    rst_n = 1'b1;
    tick();
    check("rel_s_pix_en_c1", int'(s_pix_en), 1);
    check("rel_d_pix_en_c1", int'(d_pix_en), 0);
    tick();
    check("rel_d_pix_en_c2", int'(d_pix_en), 0);
    tick();
    check("rel_d_pix_en_c3", int'(d_pix_en), 1);
    check("rel_d_fstart_c3", int'(d_frame_start), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
